// File: rtl/sweep_pkg.sv
// Shared definitions for the gate truth-table sweep driver.
//   - sweep_state_e : FSM state encoding (IDLE, DRIVE, SAMPLE, DONE)
//   - MintermW      : width of the minterm index
//   - GOLDEN_F5     : golden truth table of f = ~a & b, indexed by minterm {a,b}
package sweep_pkg;

  localparam int unsigned MintermW    = 2;
  localparam int unsigned NumMinterms = 4;
  localparam int unsigned SettleW     = 4;

  // Bit m holds f(a,b) for m = {a,b}; only minterm 1 (a=0,b=1) is true.
  localparam logic [NumMinterms-1:0] GOLDEN_F5 = 4'b0010;

  typedef enum logic [1:0] {
    StIdle,
    StDrive,
    StSample,
    StDone
  } sweep_state_e;

endpackage

// File: rtl/sweep_settle_timer.sv
// Settle countdown for the sweep driver.
// Ports:
//   clk_i      : clock
//   rst_ni     : asynchronous active-low reset
//   load_i     : load load_val_i into the counter (takes priority)
//   load_val_i : cycles-to-hold minus one
//   en_i       : count down while high
//   expire_o   : high in the last enabled cycle of the countdown
module sweep_settle_timer
  import sweep_pkg::*;
#(
  parameter int unsigned Width = SettleW
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  input  logic             en_i,
  output logic             expire_o
);

  logic [Width-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // A load value of 0 expires in the first enabled cycle, giving one cycle of hold.
  assign expire_o = en_i && !load_i && (cnt_q == '0);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/gate_sweep_driver.sv
// Truth-table sweep driver comparing two implementations of a 2-input gate.
// Walks minterms 0..3 on {x,y}, holds each for SETTLE_CYCLES, then samples
// sa/sb and records failing minterms.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : request one sweep (accepted in IDLE only)
//   sa, sb     : outputs of the structural / expression implementations
//   x, y       : driven gate inputs ({x,y} = minterm)
//   minterm    : index of the combination currently driven
//   busy       : sweep in progress (drops when done pulses)
//   done       : one-cycle pulse at end of sweep
//   err_mask   : bit m set if minterm m failed
//   err_cnt    : number of failed minterms
//   pass       : last completed sweep had no failures
// Configuration macro: SWEEP_GOLDEN_EN -- when defined, both sa and sb are
// also checked against GOLDEN_F5; otherwise only sa != sb counts as a failure.
module gate_sweep_driver
  import sweep_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                sa,
  input  logic                sb,
  output logic                x,
  output logic                y,
  output logic [MintermW-1:0] minterm,
  output logic                busy,
  output logic                done,
  output logic [3:0]          err_mask,
  output logic [2:0]          err_cnt,
  output logic                pass
);

  sweep_state_e        state_q;
  logic [MintermW-1:0] m_q;
  logic [3:0]          err_mask_q;
  logic [2:0]          err_cnt_q;
  logic                pass_q;
  logic                busy_q;
  logic                done_q;

  logic accept;
  logic next_minterm;
  logic settle_load;
  logic settle_expire;
  logic fail;

  assign accept       = (state_q == StIdle) && start;
  assign next_minterm = (state_q == StSample) && (m_q != 2'd3);
  assign settle_load  = accept || next_minterm;

  sweep_settle_timer #(
    .Width (SettleW)
  ) u_settle (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .load_i     (settle_load),
    .load_val_i (SettleW'(SETTLE_CYCLES - 1)),
    .en_i       (state_q == StDrive),
    .expire_o   (settle_expire)
  );

`ifdef SWEEP_GOLDEN_EN
  logic golden;
  assign golden = GOLDEN_F5[m_q];
  assign fail   = (sa != golden) || (sb != golden);
`else
  assign fail = (sa != sb);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      m_q        <= '0;
      err_mask_q <= '0;
      err_cnt_q  <= '0;
      pass_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q    <= StDrive;
            m_q        <= '0;
            err_mask_q <= '0;
            err_cnt_q  <= '0;
            pass_q     <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        StDrive: begin
          if (settle_expire) begin
            state_q <= StSample;
          end
        end
        StSample: begin
          if (fail) begin
            err_mask_q[m_q] <= 1'b1;
            err_cnt_q       <= err_cnt_q + 3'd1;
          end
          if (m_q == 2'd3) begin
            // Final minterm: pass must include this sample's result.
            state_q <= StDone;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            pass_q  <= (err_cnt_q == 3'd0) && !fail;
          end else begin
            m_q     <= m_q + 2'd1;
            state_q <= StDrive;
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign x        = m_q[1];
  assign y        = m_q[0];
  assign minterm  = m_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign err_mask = err_mask_q;
  assign err_cnt  = err_cnt_q;
  assign pass     = pass_q;

endmodule

// File: tb/tb_gate_sweep_driver.sv
// Bench for gate_sweep_driver: two instances (SETTLE_CYCLES = 1 and 3) share
// start/rst_n; each gets sa/sb from a behavioural gate-pair model selected by mode.
module tb_gate_sweep_driver;

  logic       clk;
  logic       rst_n;
  logic       start;
  int         mode;

  logic       sa1, sb1, x1, y1, busy1, done1, pass1;
  logic [1:0] m1;
  logic [3:0] mask1;
  logic [2:0] cnt1;

  logic       sa3, sb3, x3, y3, busy3, done3, pass3;
  logic [1:0] m3;
  logic [3:0] mask3;
  logic [2:0] cnt3;

  int checks;
  int errors;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Returns {sa, sb} for the gate pair under test; g is the correct ~a & b.
  function automatic logic [1:0] gate_model(input int md, input logic a, input logic b);
    logic g;
    g = ~a & b;
    case (md)
      0:       return {g, g};
      1:       return {1'b1, g};
      2:       return {1'b1, 1'b1};
      3:       return {g, ~g};
      4:       return {a & ~b, g};
      default: return {1'b0, 1'b0};
    endcase
  endfunction

  assign {sa1, sb1} = gate_model(mode, x1, y1);
  assign {sa3, sb3} = gate_model(mode, x3, y3);

  gate_sweep_driver #(
    .SETTLE_CYCLES (1)
  ) u_dut1 (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .sa       (sa1),
    .sb       (sb1),
    .x        (x1),
    .y        (y1),
    .minterm  (m1),
    .busy     (busy1),
    .done     (done1),
    .err_mask (mask1),
    .err_cnt  (cnt1),
    .pass     (pass1)
  );

  gate_sweep_driver #(
    .SETTLE_CYCLES (3)
  ) u_dut3 (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .sa       (sa3),
    .sb       (sb3),
    .x        (x3),
    .y        (y3),
    .minterm  (m3),
    .busy     (busy3),
    .done     (done3),
    .err_mask (mask3),
    .err_cnt  (cnt3),
    .pass     (pass3)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    int         mode;
    logic [3:0] mask;
    int         cnt;
    logic       pass;
    int         reassert;
  } vec_t;

  vec_t vecs[7];

  // One sweep: start is high for the acceptance edge (c = 0); sweep length counts
  // the acceptance cycle through the done cycle inclusive.
  task automatic run_sweep(input vec_t v, input string tag);
    int len1 = -1;
    int len3 = -1;
    int nd1  = 0;
    int nd3  = 0;
    mode = v.mode;
    @(posedge clk); #1;
    start = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      start = (v.reassert != 0) && (c >= 1) && (c <= 3);
      if (c == 0) begin
        check({tag, " busy after accept"}, int'(busy1), 1);
        check({tag, " pass cleared"}, int'(pass1), 0);
        check({tag, " mask cleared"}, int'(mask1), 0);
      end
      if ((c % 2 == 0) && (c < 8)) begin
        check({tag, " minterm"}, int'(m1), c / 2);
        check({tag, " xy"}, int'({x1, y1}), c / 2);
      end
      if (done1) begin
        nd1++;
        if (len1 < 0) begin
          len1 = c + 1;
          check({tag, " busy at done"}, int'(busy1), 0);
          check({tag, " err_mask"}, int'(mask1), int'(v.mask));
          check({tag, " err_cnt"}, int'(cnt1), v.cnt);
          check({tag, " pass"}, int'(pass1), int'(v.pass));
        end
      end
      if (done3) begin
        nd3++;
        if (len3 < 0) begin
          len3 = c + 1;
          check({tag, " err_mask n3"}, int'(mask3), int'(v.mask));
          check({tag, " err_cnt n3"}, int'(cnt3), v.cnt);
        end
      end
    end
    check({tag, " length n1"}, len1, 9);
    check({tag, " length n3"}, len3, 17);
    check({tag, " done pulses n1"}, nd1, 1);
    check({tag, " done pulses n3"}, nd3, 1);
    check({tag, " mask held"}, int'(mask1), int'(v.mask));
    check({tag, " pass held"}, int'(pass3), int'(v.pass));
  endtask

  initial begin
    int   found;
    int   nd;
    vec_t v;
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    start  = 1'b0;
    mode   = 0;

    vecs[0] = '{0, 4'b0000, 0, 1'b1, 0};
    vecs[1] = '{1, 4'b1101, 3, 1'b0, 0};
`ifdef SWEEP_GOLDEN_EN
    vecs[2] = '{2, 4'b1101, 3, 1'b0, 1};
    vecs[5] = '{5, 4'b0010, 1, 1'b0, 0};
`else
    vecs[2] = '{2, 4'b0000, 0, 1'b1, 1};
    vecs[5] = '{5, 4'b0000, 0, 1'b1, 0};
`endif
    vecs[3] = '{3, 4'b1111, 4, 1'b0, 0};
    vecs[4] = '{4, 4'b0110, 2, 1'b0, 0};
    vecs[6] = '{0, 4'b0000, 0, 1'b1, 1};

    repeat (3) @(posedge clk);
    #1;
    check("reset outputs n1", int'({x1, y1, m1, busy1, done1, mask1, cnt1, pass1}), 0);
    check("reset outputs n3", int'({x3, y3, m3, busy3, done3, mask3, cnt3, pass3}), 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) begin
      run_sweep(vecs[i], $sformatf("vec%0d", i));
    end

    // Abort a sweep mid-flight at minterm 2 with failures already recorded.
    mode = 3;
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    found = 0;
    for (int k = 0; k < 20; k++) begin
      if (m1 == 2'd2) begin
        found = 1;
        break;
      end
      @(posedge clk); #1;
    end
    check("reached minterm 2", found, 1);
    check("mask before reset", int'(mask1 != 4'b0000), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async reset n1", int'({x1, y1, m1, busy1, done1, mask1, cnt1, pass1}), 0);
    check("async reset n3", int'({x3, y3, m3, busy3, done3, mask3, cnt3, pass3}), 0);
    nd = 0;
    repeat (3) begin
      @(posedge clk); #1;
      nd += int'(done1) + int'(done3);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) begin
      @(posedge clk); #1;
      nd += int'(done1) + int'(done3);
    end
    check("no done after abort", nd, 0);
    v = '{0, 4'b0000, 0, 1'b1, 0};
    run_sweep(v, "post-reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
